// File: rtl/barrel_shift_sequencer.sv
// Multi-pass controller for a 4-bit barrel shifter. It splits a wide shift amount into passes
// of at most 3 positions, feeds each pass to the shifter and collects the shifter result.
module barrel_shift_sequencer #(
  parameter int AMOUNT_WIDTH = 4
) (
  input  logic                    Clock_In,
  input  logic                    Reset_n_In,
  input  logic                    Start_In,
  input  logic [2:0]              Mode_In,
  input  logic [AMOUNT_WIDTH-1:0] Shift_Amount_In,
  input  logic                    Carry_In,
  input  logic [3:0]              Data_In,
  output logic                    Busy_Out,
  output logic                    Done_Out,
  output logic [3:0]              Data_Out,
  output logic                    Carry_Out,
  output logic                    Shifter_Enable_Out,
  output logic [2:0]              Shifter_Mode_Out,
  output logic [1:0]              Shifter_Length_Out,
  output logic                    Shifter_Carry_Out,
  output logic [3:0]              Shifter_Data_Out,
  input  logic [3:0]              Shifter_Data_In,
  input  logic                    Shifter_Carry_In
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [AMOUNT_WIDTH-1:0] remaining;
  logic [AMOUNT_WIDTH-1:0] remaining_after;

  // Length of the next pass: the shifter handles at most 3 positions per cycle.
  function automatic logic [1:0] pass_len(input logic [AMOUNT_WIDTH-1:0] r);
    return (r > AMOUNT_WIDTH'(3)) ? 2'd3 : r[1:0];
  endfunction

  // RLC/RRC are the only modes whose carry is part of the result.
  function automatic logic through_carry(input logic [2:0] m);
    return m[2] & m[1];
  endfunction

  assign remaining_after    = remaining - AMOUNT_WIDTH'(Shifter_Length_Out);
  assign Busy_Out           = (state != IDLE);
  assign Done_Out           = (state == DONE);
  assign Shifter_Enable_Out = (state == SHIFT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start_In) state_nxt = (Shift_Amount_In == '0) ? DONE : SHIFT;
      SHIFT:   if (remaining_after == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Results are loaded on the edge that enters DONE, so they change only in the DONE cycle.
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state              <= IDLE;
      remaining          <= '0;
      Shifter_Mode_Out   <= '0;
      Shifter_Length_Out <= '0;
      Shifter_Carry_Out  <= 1'b0;
      Shifter_Data_Out   <= '0;
      Data_Out           <= '0;
      Carry_Out          <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (Start_In) begin
            Shifter_Mode_Out   <= Mode_In;
            Shifter_Data_Out   <= Data_In;
            Shifter_Carry_Out  <= Carry_In;
            remaining          <= Shift_Amount_In;
            Shifter_Length_Out <= pass_len(Shift_Amount_In);
            if (Shift_Amount_In == '0) begin
              Data_Out  <= Data_In;
              Carry_Out <= through_carry(Mode_In) ? Carry_In : 1'b0;
            end
          end
        end
        SHIFT: begin
          Shifter_Data_Out   <= Shifter_Data_In;
          Shifter_Carry_Out  <= Shifter_Carry_In;
          remaining          <= remaining_after;
          Shifter_Length_Out <= pass_len(remaining_after);
          if (remaining_after == '0) begin
            Data_Out  <= Shifter_Data_In;
            Carry_Out <= through_carry(Shifter_Mode_Out) ? Shifter_Carry_In : 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Bench for barrel_shift_sequencer: a behavioural 4-bit shifter answers each pass, and final
// results are compared against closed-form shift/rotate arithmetic.
module tb_barrel_shift_sequencer;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    mode = '0;
  logic [AW-1:0] amount = '0;
  logic          cin = 1'b0;
  logic [3:0]    din = '0;
  logic          busy, done, cout, sh_en, sh_c, res_c;
  logic [3:0]    dout, sh_d, res_d;
  logic [2:0]    sh_mode;
  logic [1:0]    sh_len;
  logic [17:0]   all_out;

  int compared = 0;
  int mismatched = 0;
  logic [3:0] hold_d = '0;
  logic       hold_c = 1'b0;

  always #5 clk = ~clk;

  barrel_shift_sequencer #(.AMOUNT_WIDTH(AW)) dut (
    .Clock_In(clk), .Reset_n_In(rst_n), .Start_In(start), .Mode_In(mode),
    .Shift_Amount_In(amount), .Carry_In(cin), .Data_In(din),
    .Busy_Out(busy), .Done_Out(done), .Data_Out(dout), .Carry_Out(cout),
    .Shifter_Enable_Out(sh_en), .Shifter_Mode_Out(sh_mode), .Shifter_Length_Out(sh_len),
    .Shifter_Carry_Out(sh_c), .Shifter_Data_Out(sh_d),
    .Shifter_Data_In(res_d), .Shifter_Carry_In(res_c)
  );

  assign all_out = {busy, done, dout, cout, sh_en, sh_mode, sh_len, sh_c, sh_d};

  // Combinational shifter: one position at a time, len positions.
  function automatic logic [4:0] shifter_pass(input logic [2:0] m, input logic [1:0] len,
                                              input logic c, input logic [3:0] d);
    logic t;
    for (int i = 0; i < int'(len); i++) begin
      case (m)
        3'd0, 3'd2: begin c = d[3]; d = {d[2:0], 1'b0}; end
        3'd1:       begin c = d[0]; d = {1'b0, d[3:1]}; end
        3'd3:       begin c = d[0]; d = {d[3], d[3:1]}; end
        3'd4:       begin c = d[3]; d = {d[2:0], d[3]}; end
        3'd5:       begin c = d[0]; d = {d[0], d[3:1]}; end
        3'd6:       begin t = d[3]; d = {d[2:0], c}; c = t; end
        default:    begin t = d[0]; d = {c, d[3:1]}; c = t; end
      endcase
    end
    return {c, d};
  endfunction

  always_comb {res_c, res_d} = shifter_pass(sh_mode, sh_len, sh_c, sh_d);

  // Expected final {carry, data} straight from the whole-amount rules.
  function automatic logic [4:0] ref_result(input logic [2:0] m, input int n,
                                            input logic c, input logic [3:0] d);
    int v, s, w, k, r, co;
    v = int'(d);
    w = int'(c) * 16 + v;
    co = 0;
    case (m)
      3'd0, 3'd2: r = (n >= 4) ? 0 : ((v << n) & 15);
      3'd1:       r = (n >= 4) ? 0 : (v >> n);
      3'd3: begin s = d[3] ? v - 16 : v; r = (s >>> n) & 15; end
      3'd4: begin k = n % 4; r = ((v << k) | (v >> (4 - k))) & 15; end
      3'd5: begin k = n % 4; r = ((v >> k) | (v << (4 - k))) & 15; end
      3'd6: begin k = n % 5; w = ((w << k) | (w >> (5 - k))) & 31; r = w & 15; co = w >> 4; end
      default: begin k = n % 5; w = ((w >> k) | (w << (5 - k))) & 31; r = w & 15; co = w >> 4; end
    endcase
    return {1'(co), 4'(r)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input logic [2:0] m, input logic [3:0] n, input logic c,
                         input logic [3:0] d, input bit glitch);
    int lat, cyc, rem, exp_len;
    bit seen;
    logic [4:0] e;
    lat = (int'(n) + 2) / 3 + 1;
    e = ref_result(m, int'(n), c, d);
    @(negedge clk);
    check("idle_busy_at_start", busy, 0);
    mode = m; amount = n; cin = c; din = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = 3'($urandom); amount = AW'($urandom); cin = 1'($urandom); din = 4'($urandom);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = glitch && (cyc == 1);
      if (done) seen = 1;
      else begin
        rem = int'(n) - 3 * (cyc - 1);
        exp_len = (rem > 3) ? 3 : ((rem < 0) ? 0 : rem);
        check("shift_enable", sh_en, 1);
        check("shift_length", sh_len, exp_len);
        check("shift_busy", busy, 1);
        check("shift_hold_result", {cout, dout}, {hold_c, hold_d});
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    check("latency", cyc, lat);
    check("done_busy", busy, 1);
    check("done_enable", sh_en, 0);
    check("result", {cout, dout}, e);
    {hold_c, hold_d} = e;
    @(negedge clk);
    check("done_single_pulse", done, 0);
    check("idle_after_done", busy, 0);
    check("result_held", {cout, dout}, {hold_c, hold_d});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", all_out, 0);
    rst_n = 1'b1;

    run_req(3'd0, 4'd5, 1'b0, 4'b1011, 1'b0);
    run_req(3'd4, 4'd7, 1'b0, 4'b1001, 1'b0);
    run_req(3'd6, 4'd4, 1'b0, 4'b0001, 1'b0);
    run_req(3'd7, 4'd5, 1'b0, 4'b0001, 1'b0);
    run_req(3'd3, 4'd9, 1'b0, 4'b1000, 1'b0);
    run_req(3'd1, 4'd0, 1'b1, 4'b1010, 1'b0);
    run_req(3'd6, 4'd0, 1'b1, 4'b0110, 1'b0);
    run_req(3'd0, 4'd15, 1'b1, 4'b0001, 1'b0);
    run_req(3'd5, 4'd11, 1'b1, 4'b0110, 1'b1);

    // Reset in the middle of a long request.
    @(negedge clk);
    mode = 3'd7; amount = 4'd15; cin = 1'b1; din = 4'b1101; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_before_reset", busy, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", all_out, 0);
    repeat (3) begin
      @(negedge clk);
      check("no_done_in_reset", {busy, done}, 0);
    end
    rst_n = 1'b1;
    {hold_c, hold_d} = 5'd0;
    run_req(3'd6, 4'd13, 1'b1, 4'b0101, 1'b0);

    for (int i = 0; i < 40; i++)
      run_req(3'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom_range(0, 3) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
